// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between the fetch and data requesters,
// sequencing each access through IDLE -> BUSY -> RESP and routing the response back.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_we,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_i_val,
    output logic              mem_op_type,
    input  logic [DATA_W-1:0] mem_o_val
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t     state_q, state_d;
    logic [3:0] lat_cnt;
    logic [3:0] data_run;
    logic       owner_fetch;
    logic       starve;

    always_comb begin
        state_d = state_q;
        d_gnt   = 1'b0;
        i_gnt   = 1'b0;
        starve  = d_req & i_req & (data_run == 4'(MAX_DATA_RUN));
        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (i_req & (starve | ~d_req)) i_gnt = 1'b1;
                    else if (d_req)                d_gnt = 1'b1;
                end
                if (d_gnt | i_gnt) state_d = BUSY;
            end
            BUSY:    if (lat_cnt == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt     <= '0;
            data_run    <= '0;
            owner_fetch <= 1'b0;
            d_rdata     <= '0;
            i_rdata     <= '0;
            d_rvalid    <= 1'b0;
            i_rvalid    <= 1'b0;
            mem_en      <= 1'b0;
            mem_address <= '0;
            mem_i_val   <= '0;
            mem_op_type <= 1'b0;
        end else begin
            d_rvalid <= 1'b0;
            i_rvalid <= 1'b0;

            // Run length only matters while fetch is actually waiting.
            if (!i_req || i_gnt)
                data_run <= '0;
            else if (d_gnt && data_run != 4'hF)
                data_run <= data_run + 4'd1;

            if (d_gnt || i_gnt) begin
                mem_en      <= 1'b1;
                mem_address <= i_gnt ? i_addr : d_addr;
                mem_i_val   <= i_gnt ? '0 : d_wdata;
                mem_op_type <= d_gnt & d_we;
                owner_fetch <= i_gnt;
                lat_cnt     <= 4'(MEM_LATENCY - 1);
            end

            if (state_q == BUSY) begin
                if (lat_cnt == '0) begin
                    mem_en      <= 1'b0;
                    mem_op_type <= 1'b0;
                    if (owner_fetch) begin
                        i_rvalid <= 1'b1;
                        if (!mem_op_type) i_rdata <= mem_o_val;
                    end else begin
                        d_rvalid <= 1'b1;
                        if (!mem_op_type) d_rdata <= mem_o_val;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    assign i_stall = i_req & ~i_rvalid;

endmodule
